// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_arb_pkg;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam logic [1:0] BE_ALL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } arb_port_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 16-bit memory port between instruction fetch (I)
// and data load/store (D). One transaction at a time, command registered on
// grant, at least one idle cycle with strobes low between transactions.
// Build option MEM_ARBITER_RR_EN: round-robin on simultaneous requests;
// otherwise D wins ties.
module mem_arbiter #(
    parameter int AW = mem_arb_pkg::AW,
    parameter int DW = mem_arb_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          imem_read,
    input  logic [AW-1:0] imem_address,
    output logic          imem_resp,
    output logic [DW-1:0] imem_rdata,
    input  logic          dmem_read,
    input  logic          dmem_write,
    input  logic [1:0]    dmem_byte_enable,
    input  logic [AW-1:0] dmem_address,
    input  logic [DW-1:0] dmem_wdata,
    output logic          dmem_resp,
    output logic [DW-1:0] dmem_rdata,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [1:0]    pmem_byte_enable,
    output logic [AW-1:0] pmem_address,
    output logic [DW-1:0] pmem_wdata,
    input  logic          pmem_resp,
    input  logic [DW-1:0] pmem_rdata
);

    import mem_arb_pkg::*;

    arb_state_t state;
    arb_state_t state_next;
    arb_port_t  winner;
    logic       i_req;
    logic       d_req;

`ifdef MEM_ARBITER_RR_EN
    arb_port_t  last_grant;
`endif

    assign i_req = imem_read;
    assign d_req = dmem_read | dmem_write;

    // Winner when at least one request is pending; a lone requester always wins.
    function automatic arb_port_t pick_winner(input logic ireq, input logic dreq);
        if (ireq && dreq) begin
`ifdef MEM_ARBITER_RR_EN
            return (last_grant == PORT_I) ? PORT_D : PORT_I;
`else
            return PORT_D;
`endif
        end
        return dreq ? PORT_D : PORT_I;
    endfunction

    assign winner = pick_winner(i_req, d_req);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and combinational completion routed to the granted port only.
    always_comb begin
        state_next = state;
        imem_resp  = 1'b0;
        dmem_resp  = 1'b0;
        imem_rdata = '0;
        dmem_rdata = '0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_next = (winner == PORT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    imem_resp  = 1'b1;
                    imem_rdata = pmem_rdata;
                    state_next = IDLE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = pmem_rdata;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory command registers: loaded on grant, strobes dropped on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_byte_enable <= '0;
            pmem_address     <= '0;
            pmem_wdata       <= '0;
        end else begin
            if (state == IDLE) begin
                if (state_next == SERVE_I) begin
                    pmem_read        <= 1'b1;
                    pmem_write       <= 1'b0;
                    pmem_byte_enable <= BE_ALL;
                    pmem_address     <= imem_address;
                end else if (state_next == SERVE_D) begin
                    // read+write together is a write
                    pmem_read        <= ~dmem_write;
                    pmem_write       <= dmem_write;
                    pmem_byte_enable <= dmem_write ? dmem_byte_enable : BE_ALL;
                    pmem_address     <= dmem_address;
                    pmem_wdata       <= dmem_wdata;
                end
            end else if (pmem_resp) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
            end
        end
    end

`ifdef MEM_ARBITER_RR_EN
    // Remember the most recent grant for round-robin tie breaking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_I;
        end else if (state == IDLE && (i_req || d_req)) begin
            last_grant <= winner;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_byte_enable(dmem_byte_enable), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_byte_enable(pmem_byte_enable), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h3C5A;
    endfunction

    // Physical memory behind the port, and the bench's own view of its contents.
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];

    // ---------------- memory responder ----------------
    int fixed_lat = 1;
    int cur_lat   = 1;
    int mem_cnt   = 0;
    bit spur_en   = 1'b0;

    initial begin
        logic [7:0] idx;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (rst_n && (pmem_read || pmem_write)) begin
                mem_cnt++;
                if (mem_cnt == 1) cur_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
                if (mem_cnt >= cur_lat) begin
                    mem_cnt    = 0;
                    idx        = pmem_address[8:1];
                    pmem_resp  = 1'b1;
                    pmem_rdata = mem[idx];
                    if (pmem_write) begin
                        if (pmem_byte_enable[0]) mem[idx][7:0]  = pmem_wdata[7:0];
                        if (pmem_byte_enable[1]) mem[idx][15:8] = pmem_wdata[15:8];
                    end
                end
            end else begin
                mem_cnt = 0;
                if (spur_en && $urandom_range(0, 5) == 0) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = 16'($urandom);
                end
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    bit          m_active = 1'b0;
    bit          m_resp   = 1'b0;
    bit          m_ireq   = 1'b0;
    bit          m_dreq   = 1'b0;
    logic [15:0] m_iaddr, m_daddr, m_dwdata;
    bit          m_dwrite;
    logic [1:0]  m_dbe;
    bit          lg  = 1'b0;   // last granted port, 1 = D
    bit          srv = 1'b0;   // port currently being served, 1 = D
    logic [15:0] srv_addr, srv_wdata;
    logic [1:0]  srv_be;
    bit          srv_wr;

    // 1 = D wins the grant among the requests pending in an idle cycle
    function automatic bit pick(input bit i, input bit d);
        if (i && d) begin
`ifdef MEM_ARBITER_RR_EN
            return !lg;
`else
            return 1'b1;
`endif
        end
        return d;
    endfunction

    initial begin
        bit          act;
        bit          w;
        logic [19:0] exp_cmd;
        logic [15:0] exp_rd;
        logic [7:0]  idx;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_pmem", {pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata}, '0);
                check("rst_resp", {imem_resp, dmem_resp, imem_rdata, dmem_rdata}, '0);
                m_active = 1'b0; m_resp = 1'b0; m_ireq = 1'b0; m_dreq = 1'b0; lg = 1'b0;
            end else begin
                act = pmem_read | pmem_write;
                // strobe held until completion, then low for at least one cycle,
                // and raised in the cycle after any request seen while idle
                check("strobe", act, m_active ? !m_resp : (m_ireq | m_dreq));
                if (act && !m_active) begin
                    w   = pick(m_ireq, m_dreq);
                    lg  = w;
                    srv = w;
                    if (!w) begin
                        srv_addr = m_iaddr; srv_wr = 1'b0;
                        exp_cmd  = {1'b1, 1'b0, 2'b11, m_iaddr};
                    end else begin
                        srv_addr = m_daddr; srv_wr = m_dwrite;
                        srv_wdata = m_dwdata; srv_be = m_dbe;
                        exp_cmd  = {!m_dwrite, m_dwrite, (m_dwrite ? m_dbe : 2'b11), m_daddr};
                    end
                    check("cmd", {pmem_read, pmem_write, pmem_byte_enable, pmem_address}, exp_cmd);
                    if (srv_wr) check("wdata", pmem_wdata, srv_wdata);
                end
                if (pmem_resp && act) begin
                    idx = srv_addr[8:1];
                    check("resp", {imem_resp, dmem_resp}, srv ? 2'b01 : 2'b10);
                    exp_rd = srv_wr ? pmem_rdata : ref_mem[idx];
                    check("rdata", srv ? dmem_rdata : imem_rdata, exp_rd);
                    if (srv_wr) begin
                        if (srv_be[0]) ref_mem[idx][7:0]  = srv_wdata[7:0];
                        if (srv_be[1]) ref_mem[idx][15:8] = srv_wdata[15:8];
                    end
                end else begin
                    check("noresp", {imem_resp, dmem_resp}, 2'b00);
                end
                m_active = act;
                m_resp   = pmem_resp;
                m_ireq   = imem_read;
                m_dreq   = dmem_read | dmem_write;
                m_iaddr  = imem_address;
                m_daddr  = dmem_address;
                m_dwdata = dmem_wdata;
                m_dwrite = dmem_write;
                m_dbe    = dmem_byte_enable;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_resp(input bit is_d, output int cyc);
        cyc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (is_d ? dmem_resp : imem_resp) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_iread(input logic [15:0] a, output logic [15:0] d, output bit ok);
        int cyc;
        @(posedge clk); #1;
        imem_read = 1'b1; imem_address = a;
        wait_resp(1'b0, cyc);
        ok = (cyc >= 0);
        d  = imem_rdata;
        @(posedge clk); #1;
        imem_read = 1'b0;
    endtask

    task automatic do_dop(input bit wr, input bit rd, input logic [1:0] be,
                          input logic [15:0] a, input logic [15:0] wd, output bit ok);
        int cyc;
        @(posedge clk); #1;
        dmem_write = wr; dmem_read = rd; dmem_byte_enable = be;
        dmem_address = a; dmem_wdata = wd;
        wait_resp(1'b1, cyc);
        ok = (cyc >= 0);
        @(posedge clk); #1;
        dmem_write = 1'b0; dmem_read = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          ok, gi, gd, si, sd, ip, dp;
        int          c1, c2, ti, td, nresp, r;
        logic [15:0] rd, w;

        imem_read = 1'b0; imem_address = '0;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_byte_enable = '0;
        dmem_address = '0; dmem_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        mem[8'h20] = 16'hBEEF;
        ref_mem[8'h20] = 16'hBEEF;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // 1: reset in the middle of a D write
        fixed_lat = 6;
        @(posedge clk); #1;
        dmem_write = 1'b1; dmem_address = 16'h0044; dmem_wdata = 16'hDEAD; dmem_byte_enable = 2'b11;
        wait_strobe(ok);
        check("t1_grant", ok, 1'b1);
        @(posedge clk); #3 rst_n = 1'b0;
        @(negedge clk);
        check("t1_strobe_low", {pmem_read, pmem_write}, 2'b00);
        @(posedge clk); #1;
        dmem_write = 1'b0;
        spur_en = 1'b1;
        #2 rst_n = 1'b1;
        nresp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (imem_resp || dmem_resp) nresp++;
        end
        spur_en = 1'b0;
        check("t1_noresp", nresp, 0);
        w = init_word(8'h22);
        check("t1_nowrite", mem[8'h22], w);

        // 2: single I read
        fixed_lat = 2;
        do_iread(16'h0040, rd, ok);
        check("t2_done", ok, 1'b1);
        check("t2_rdata", rd, 16'hBEEF);

        // 3: D byte write then I read of the same word
        do_dop(1'b1, 1'b0, 2'b01, 16'h0101, 16'h12AB, ok);
        check("t3_wdone", ok, 1'b1);
        do_iread(16'h0100, rd, ok);
        w = init_word(8'h80);
        check("t3_rdata", rd, {w[15:8], 8'hAB});

        // 4: tie, preceded by a D-only grant
        fixed_lat = 1;
        do_dop(1'b0, 1'b1, 2'b11, 16'h0200, 16'h0000, ok);
        check("t4_pre", ok, 1'b1);
        @(posedge clk); #1;
        imem_read = 1'b1; imem_address = 16'h0000;
        dmem_read = 1'b1; dmem_address = 16'h0200;
        ti = -1; td = -1;
        for (int k = 0; k < 30 && (ti < 0 || td < 0); k++) begin
            @(negedge clk);
            gi = imem_resp; gd = dmem_resp;
            if (gi && ti < 0) ti = k;
            if (gd && td < 0) td = k;
            if (gi || gd) begin
                @(posedge clk); #1;
                if (gi) imem_read = 1'b0;
                if (gd) dmem_read = 1'b0;
            end
        end
        imem_read = 1'b0; dmem_read = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        check("t4_order_i_first", (ti >= 0) && (ti < td), 1'b1);
        check("t4_gap", td - ti, 2);
`else
        check("t4_order_d_first", (td >= 0) && (td < ti), 1'b1);
        check("t4_gap", ti - td, 2);
`endif

        // 5: D back-to-back
        @(posedge clk); #1;
        dmem_read = 1'b1; dmem_address = 16'h0010;
        wait_resp(1'b1, c1);
        @(posedge clk); #1;
        dmem_address = 16'h0030;
        wait_resp(1'b1, c2);
        check("t5_first", c1 >= 0, 1'b1);
        check("t5_bubble", c2, 1);
        check("t5_addr", pmem_address, 16'h0030);
        @(posedge clk); #1;
        dmem_read = 1'b0;

        // 6: I withdraws mid-transaction
        fixed_lat = 4;
        @(posedge clk); #1;
        imem_read = 1'b1; imem_address = 16'h0060;
        wait_strobe(ok);
        check("t6_grant", ok, 1'b1);
        @(posedge clk); #1;
        imem_read = 1'b0;
        nresp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem_resp) nresp++;
        end
        check("t6_resp", nresp, 1);

        // random traffic
        fixed_lat = 0;
        spur_en = 1'b1;
        ip = 1'b0; dp = 1'b0;
        for (int c = 0; c < 2060; c++) begin
            if (c >= 2000 && !ip && !dp) break;
            @(negedge clk); #1;
            gi = imem_resp; gd = dmem_resp;
            si = m_active && !m_resp && !srv;
            sd = m_active && !m_resp && srv;
            @(posedge clk); #1;
            if (gi) begin ip = 1'b0; imem_read = 1'b0; end
            if (gd) begin dp = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; end
            if (!ip) begin
                if (c < 2000 && $urandom_range(0, 2) == 0) begin
                    ip = 1'b1; imem_read = 1'b1; imem_address = 16'($urandom);
                end
            end else if (si) begin
                r = $urandom_range(0, 7);
                if (r == 0) imem_read = 1'b0;
                else if (r == 1) imem_address = 16'($urandom);
            end
            if (!dp) begin
                if (c < 2000 && $urandom_range(0, 2) == 0) begin
                    r = $urandom_range(0, 3);
                    dp = 1'b1;
                    dmem_read  = (r != 1);
                    dmem_write = (r == 1 || r == 2);
                    dmem_address = 16'($urandom);
                    dmem_wdata = 16'($urandom);
                    dmem_byte_enable = 2'($urandom);
                end
            end else if (sd) begin
                r = $urandom_range(0, 7);
                if (r == 0) begin
                    dmem_read = 1'b0; dmem_write = 1'b0;
                end else if (r == 1) begin
                    dmem_address = 16'($urandom);
                    dmem_wdata = 16'($urandom);
                    dmem_byte_enable = 2'($urandom);
                end
            end
        end
        check("drain", {ip, dp}, 2'b00);
        spur_en = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
